// File: rtl/random_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : random_pkg                                                  |
// | Desc   : Shared constants and FSM state type for random_lfsr.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package random_pkg;

  // Maximal-length Galois feedback masks for common LFSR widths
  localparam logic [7:0]  POLY8  = 8'hB8;
  localparam logic [15:0] POLY16 = 16'hB400;
  localparam logic [31:0] POLY32 = 32'h80200003;

  // Default reset seed; must be nonzero
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // FILL searches for an accepted candidate, HOLD presents one
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : lfsr_core                                                   |
// | Desc   : Right-shifting Galois LFSR with step enable and seed load.  |
// |          An all-zero load value is replaced by SEED to avoid lockup. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module lfsr_core
  import random_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = POLY16,
  parameter logic [W-1:0] SEED = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  // Reset beats load, load beats step; otherwise the state is frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? POLY : '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/random_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : random_lfsr                                                 |
// | Desc   : Uniform pseudo-random numbers in [0, MODULUS-1] from a      |
// |          Galois LFSR by rejection sampling, with valid/ready output. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module random_lfsr
  import random_pkg::*;
#(
  parameter int                MODULUS = 10,
  parameter int                NBITS   = $clog2(MODULUS),
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] POLY    = POLY16,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              ready,
  output logic              valid,
  output logic [NBITS-1:0]  number
);

  generate
    if (MODULUS < 2 || NBITS > LFSR_W || SEED == '0) begin : g_param_error
      $fatal(1, "random_lfsr: illegal parameters (MODULUS>=2, NBITS<=LFSR_W, SEED!=0)");
    end
  endgenerate

  // MODULUS fits in NBITS+1 bits, so the compare needs no wider operands
  localparam logic [NBITS:0] MOD_LIMIT = MODULUS[NBITS:0];

  fsm_t              fsm;
  logic [LFSR_W-1:0] lfsr_state;
  logic [NBITS-1:0]  cand;
  logic              accept;
  logic              eval;

  // Candidate is the low bits of the state before it steps
  assign cand   = NBITS'(lfsr_state);
  assign accept = ({1'b0, cand} < MOD_LIMIT);
  // The generator only advances when a sample is being produced or consumed
  assign eval   = (fsm == FILL) || ready;

  lfsr_core #(
    .W    (LFSR_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .step     (eval),
    .load     (seed_load),
    .load_val (seed),
    .state    (lfsr_state)
  );

  // Sample FSM: reseed voids any concurrent transfer; rejections drop to FILL
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= FILL;
      valid  <= 1'b0;
      number <= '0;
    end else if (seed_load) begin
      fsm    <= FILL;
      valid  <= 1'b0;
    end else if (eval) begin
      if (accept) begin
        number <= cand;
        valid  <= 1'b1;
        fsm    <= HOLD;
      end else begin
        valid  <= 1'b0;
        fsm    <= FILL;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_random_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_random_lfsr                                              |
// | Desc   : Self-checking bench for random_lfsr (MODULUS 10 and 16).    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_random_lfsr;

  logic        clk;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        ready;
  logic        valid_a, valid_b;
  logic [3:0]  number_a, number_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  random_lfsr #(.MODULUS(10)) dut_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .ready(ready), .valid(valid_a), .number(number_a)
  );

  random_lfsr #(.MODULUS(16)) dut_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .ready(ready), .valid(valid_b), .number(number_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what a consumer should see, cycle by cycle
  typedef struct packed {
    logic [15:0] state;
    logic        valid;
    logic [3:0]  number;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_step(mdl_t m, int modulus, logic r, logic ld,
                                    logic [15:0] sd, logic rdy);
    mdl_t n = m;
    int   c;
    if (r) begin
      n.state = 16'hACE1; n.valid = 1'b0; n.number = 4'd0;
    end else if (ld) begin
      n.state = (sd == 16'd0) ? 16'hACE1 : sd;
      n.valid = 1'b0;
    end else if (!m.valid || rdy) begin
      c = int'(m.state) % 16;
      n.state = (m.state / 2) ^ (m.state[0] ? 16'hB400 : 16'h0000);
      if (c < modulus) begin
        n.number = c[3:0];
        n.valid  = 1'b1;
      end else begin
        n.valid  = 1'b0;
      end
    end
    return n;
  endfunction

  // Advance both models on the same edge the DUTs see
  always @(posedge clk) begin
    ma <= mdl_step(ma, 10, rst, seed_load, seed, ready);
    mb <= mdl_step(mb, 16, rst, seed_load, seed, ready);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_valid",  {31'd0, valid_a},  {31'd0, ma.valid});
      check("a_number", {28'd0, number_a}, {28'd0, ma.number});
      check("a_state",  {16'd0, dut_a.lfsr_state}, {16'd0, ma.state});
      check("b_valid",  {31'd0, valid_b},  {31'd0, mb.valid});
      check("b_number", {28'd0, number_b}, {28'd0, mb.number});
      check("b_state",  {16'd0, dut_b.lfsr_state}, {16'd0, mb.state});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(string name, logic v, logic [3:0] n);
    check({name, "_valid"},  {31'd0, valid_a}, {31'd0, v});
    check({name, "_number"}, {28'd0, number_a}, {28'd0, n});
  endtask

  int hist_a[16];
  int hist_b[16];
  int tot_a, tot_b, ret_a, ret_b, bad_range, zero_state;
  logic [15:0] s0;

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = 16'd0; ready = 1'b0;

    // ---- Reset state
    tick();
    cmp_en = 1;
    tick();
    expect_a("reset", 1'b0, 4'd0);
    check("reset_state", {16'd0, dut_a.lfsr_state}, 32'hACE1);

    // ---- Free-running sequence with ready held high
    rst = 1'b0; ready = 1'b1;
    tick(); expect_a("seq0", 1'b1, 4'd1);
    tick(); expect_a("seq1", 1'b1, 4'd0);
    tick(); expect_a("seq2", 1'b1, 4'd8);
    tick(); check("seq_rej12", {31'd0, valid_a}, 32'd0);
    tick(); check("seq_rej14", {31'd0, valid_a}, 32'd0);
    tick(); expect_a("seq3", 1'b1, 4'd7);

    // ---- Back-pressure: hold for five cycles
    rst = 1'b1; ready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); expect_a("hold_first", 1'b1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_a("hold", 1'b1, 4'd1);
      check("hold_state", {16'd0, dut_a.lfsr_state}, 32'hE270);
    end
    ready = 1'b1;
    tick(); expect_a("resume", 1'b1, 4'd0);

    // ---- Zero seed load while in HOLD substitutes the default seed
    seed_load = 1'b1; seed = 16'h0000; ready = 1'b0;
    tick();
    expect_a("zero_seed", 1'b0, 4'd0);
    check("zero_seed_state", {16'd0, dut_a.lfsr_state}, 32'hACE1);
    seed_load = 1'b0; ready = 1'b1;
    tick(); expect_a("zero_seed_restart", 1'b1, 4'd1);

    // ---- Seed load concurrent with a transfer voids the transfer
    seed_load = 1'b1; seed = 16'h0003; ready = 1'b1;
    tick();
    check("void_xfer_valid", {31'd0, valid_a}, 32'd0);
    check("void_xfer_state", {16'd0, dut_a.lfsr_state}, 32'h0003);
    seed_load = 1'b0;
    tick();
    expect_a("seed3", 1'b1, 4'd3);
    check("seed3_state", {16'd0, dut_a.lfsr_state}, 32'hB401);

    // ---- Reset mid-HOLD together with seed_load
    ready = 1'b0; rst = 1'b1; seed_load = 1'b1; seed = 16'h1234;
    tick();
    expect_a("rst_hold", 1'b0, 4'd0);
    check("rst_hold_state", {16'd0, dut_a.lfsr_state}, 32'hACE1);

    // ---- Reset mid-FILL (seed 12 is rejected on MODULUS 10)
    rst = 1'b0; seed_load = 1'b1; seed = 16'h000C;
    tick();
    seed_load = 1'b0; ready = 1'b1;
    tick();
    check("fill_entered", {31'd0, valid_a}, 32'd0);
    rst = 1'b1; seed_load = 1'b1; seed = 16'h5555;
    tick();
    expect_a("rst_fill", 1'b0, 4'd0);
    check("rst_fill_state", {16'd0, dut_a.lfsr_state}, 32'hACE1);

    // ---- Long run: one full period with ready high
    seed_load = 1'b0; ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    s0 = ma.state;
    tot_a = 0; tot_b = 0; ret_a = 0; ret_b = 0; bad_range = 0; zero_state = 0;
    for (int v = 0; v < 16; v++) begin hist_a[v] = 0; hist_b[v] = 0; end
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (valid_a) begin
        if (number_a >= 4'd10) bad_range++;
        else hist_a[number_a]++;
        tot_a++;
      end
      if (valid_b) begin hist_b[number_b]++; tot_b++; end
      if (dut_a.lfsr_state == 16'd0 || dut_b.lfsr_state == 16'd0) zero_state++;
      if (ret_a == 0 && dut_a.lfsr_state == s0) ret_a = i;
      if (ret_b == 0 && dut_b.lfsr_state == s0) ret_b = i;
    end
    check("period_a", ret_a, 65535);
    check("period_b", ret_b, 65535);
    check("range_violations", bad_range, 0);
    check("zero_state", zero_state, 0);
    for (int v = 0; v < 10; v++) begin
      int d = hist_a[v] * 10 - tot_a;
      if (d < 0) d = -d;
      check("hist_a_uniform", {31'd0, (d * 10 <= tot_a)}, 32'd1);
    end
    for (int v = 0; v < 16; v++) begin
      int d = hist_b[v] * 16 - tot_b;
      if (d < 0) d = -d;
      check("hist_b_uniform", {31'd0, (d * 10 <= tot_b)}, 32'd1);
    end

    // ---- Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      seed_load = ($urandom_range(0, 39) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      ready     = 1'($urandom_range(0, 1));
      tick();
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
